// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, operand width
// and the multiply sequencer state type.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_1bit.sv
// One ripple slice of the ALU: and/or/add/less select.
// The carry-in of slice 0 doubles as the subtract +1.
module alu_1bit (
    input  logic       a,
    input  logic       b,
    input  logic       binvert,
    input  logic       cin,
    input  logic       less,
    input  logic [1:0] sel,
    output logic       res,
    output logic       sum,
    output logic       cout
);

    logic bb;

    assign bb   = b ^ binvert;
    assign sum  = a ^ bb ^ cin;
    assign cout = (a & bb) | (cin & (a ^ bb));

    // Result select for this slice.
    always_comb begin
        unique case (sel)
            2'd0:    res = a & bb;
            2'd1:    res = a | bb;
            2'd2:    res = sum;
            default: res = less;
        endcase
    end

endmodule

// File: rtl/alu_32bits.sv
// 32-bit ripple ALU built from alu_1bit slices.
// No carry-out is exported; the output is forced to 0 in reset.
module alu_32bits
    import alu_pkg::*;
(
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [5:0]  signal,
    input  logic        binvert,
    input  logic        reset,
    output logic [31:0] out
);

    logic [1:0]  sel;
    logic [31:0] cin;
    logic [31:0] cout;
    logic [31:0] sum;
    logic [31:0] res;
    logic        unused_cout;

    // Map the function code onto the slice result select.
    always_comb begin
        sel = 2'd2;
        case (signal)
            FN_AND:  sel = 2'd0;
            FN_OR:   sel = 2'd1;
            FN_SLT:  sel = 2'd3;
            default: sel = 2'd2;
        endcase
    end

    assign cin         = {cout[30:0], binvert};
    assign unused_cout = cout[31];

    for (genvar i = 0; i < 32; i++) begin : g_bit
        alu_1bit u_bit (
            .a       (in0[i]),
            .b       (in1[i]),
            .binvert (binvert),
            .cin     (cin[i]),
            .less    ((i == 0) ? sum[31] : 1'b0),
            .sel     (sel),
            .res     (res[i]),
            .sum     (sum[i]),
            .cout    (cout[i])
        );
    end

    assign out = reset ? 32'd0 : res;

endmodule

// File: rtl/msb_carry.sv
// Recovers the carry-out of an add from the operand
// and sum MSBs, since the ALU does not export it.
module msb_carry (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic c
);

    assign c = (a & b) | ((a | b) & ~s);

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add 32x32->64 unsigned multiplier that borrows the
// shared execute-stage ALU as its adder, one add per cycle.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] mcand,
    input  logic [DATA_W-1:0] mplier,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] prod_hi,
    output logic [DATA_W-1:0] prod_lo,
    output logic [DATA_W-1:0] alu_in0,
    output logic [DATA_W-1:0] alu_in1,
    output logic [5:0]        alu_signal,
    output logic              alu_binvert,
    output logic              alu_reset,
    input  logic [DATA_W-1:0] alu_out
);

    state_t            state;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] mc;
    logic [4:0]        cnt;
    logic              carry;

    assign busy    = (state == ST_CALC);
    assign done    = (state == ST_DONE);
    assign prod_hi = hi;
    assign prod_lo = lo;

    // ALU is only ours while calculating; park it at 0+0 otherwise.
    always_comb begin
        alu_in0     = '0;
        alu_in1     = '0;
        alu_signal  = FN_ADD;
        alu_binvert = 1'b0;
        if (busy) begin
            alu_in0 = hi;
            alu_in1 = lo[0] ? mc : '0;
        end
    end

    assign alu_reset = reset;

    msb_carry u_carry (
        .a (alu_in0[DATA_W-1]),
        .b (alu_in1[DATA_W-1]),
        .s (alu_out[DATA_W-1]),
        .c (carry)
    );

    // Sequencer: accept in IDLE/DONE, then 32 add-and-shift steps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            hi    <= '0;
            lo    <= '0;
            mc    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_CALC: begin
                    hi  <= {carry, alu_out[DATA_W-1:1]};
                    lo  <= {alu_out[0], lo[DATA_W-1:1]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= ST_DONE;
                end
                default: begin
                    if (start) begin
                        hi    <= '0;
                        lo    <= mplier;
                        mc    <= mcand;
                        cnt   <= '0;
                        state <= ST_CALC;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq wired to a real alu_32bits: vector table,
// random operands against a 64-bit multiply model, corner sequences.
module tb_alu_mul_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [31:0] prod_hi;
    logic [31:0] prod_lo;
    logic [31:0] alu_in0;
    logic [31:0] alu_in1;
    logic [5:0]  alu_signal;
    logic        alu_binvert;
    logic        alu_reset;
    logic [31:0] alu_out;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_mul_seq #(.DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mcand       (mcand),
        .mplier      (mplier),
        .busy        (busy),
        .done        (done),
        .prod_hi     (prod_hi),
        .prod_lo     (prod_lo),
        .alu_in0     (alu_in0),
        .alu_in1     (alu_in1),
        .alu_signal  (alu_signal),
        .alu_binvert (alu_binvert),
        .alu_reset   (alu_reset),
        .alu_out     (alu_out)
    );

    alu_32bits u_alu (
        .in0     (alu_in0),
        .in1     (alu_in1),
        .signal  (alu_signal),
        .binvert (alu_binvert),
        .reset   (alu_reset),
        .out     (alu_out)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, got, exp);
    endtask

    // Present operands with start for one edge (the accept edge E0).
    task automatic go(input logic [31:0] a, input logic [31:0] b);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges after E0 until done, and cycles with busy high.
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = busy ? 1 : 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bc++;
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    initial begin
        int n;
        int bc;
        int dn;
        int d1;
        int d2;
        logic [63:0] p1;
        logic [63:0] p2;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0] = '{32'd3, 32'd5, 64'd15};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        tbl[2] = '{32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000};
        tbl[3] = '{32'd0, 32'h1234_5678, 64'd0};
        tbl[4] = '{32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678};
        tbl[5] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

        reset  = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        chk("alu_reset_pass", 64'(alu_reset), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("alu_reset_low", 64'(alu_reset), 64'd0);
        chk("idle_alu_in", {alu_in0, alu_in1}, 64'd0);
        chk("idle_alu_fn", {57'd0, alu_binvert, alu_signal},
            64'(FN_ADD));

        go(32'd3, 32'd5);
        wait_done(n, bc);
        chk("lat_3x5", 64'(n), 64'd32);
        chk("busy_cycles", 64'(bc), 64'd32);
        chk("busy_in_done", 64'(busy), 64'd0);
        chk("prod_3x5", {prod_hi, prod_lo}, 64'd15);
        @(posedge clk);
        #1;
        chk("done_pulse", 64'(done), 64'd0);
        chk("prod_hold", {prod_hi, prod_lo}, 64'd15);

        for (int i = 0; i < 6; i++) begin
            go(tbl[i].a, tbl[i].b);
            wait_done(n, bc);
            chk($sformatf("tbl%0d_lat", i), 64'(n), 64'd32);
            chk($sformatf("tbl%0d_prod", i), {prod_hi, prod_lo}, tbl[i].p);
        end

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'hFFFF_FFFF;
            go(ra, rb);
            wait_done(n, bc);
            chk($sformatf("rnd%0d", i), {prod_hi, prod_lo}, model(ra, rb));
        end

        go(32'd1000, 32'd1000);
        repeat (10) @(posedge clk);
        #1;
        mcand  = 32'd5;
        mplier = 32'd5;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dn = 0;
        p1 = '0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                dn++;
                p1 = {prod_hi, prod_lo};
            end
            @(posedge clk);
            #1;
        end
        chk("ign_start_dones", 64'(dn), 64'd1);
        chk("ign_start_prod", p1, 64'd1000000);

        go(32'hDEAD_BEEF, 32'h1234);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_prod", {prod_hi, prod_lo}, 64'd0);
        chk("midrst_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("midrst_no_done", 64'(dn), 64'd0);
        go(32'd7, 32'd9);
        wait_done(n, bc);
        chk("after_rst_lat", 64'(n), 64'd32);
        chk("after_rst_prod", {prod_hi, prod_lo}, 64'd63);

        mcand  = 32'd6;
        mplier = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        mcand  = 32'h0001_0000;
        mplier = 32'h0001_0000;
        n  = 0;
        d1 = -1;
        d2 = -1;
        p1 = '0;
        p2 = '0;
        while (d2 < 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    p1 = {prod_hi, prod_lo};
                end else begin
                    d2 = n;
                    p2 = {prod_hi, prod_lo};
                end
            end
        end
        start = 1'b0;
        chk("held_done1", 64'(d1), 64'd32);
        chk("held_prod1", p1, 64'd42);
        chk("held_done2", 64'(d2), 64'd65);
        chk("held_prod2", p2, 64'h0000_0001_0000_0000);

        @(posedge clk);
        #1;
        chk("held_idle", {62'd0, busy, done}, 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
